// File: rtl/tim_cfg_pkg.sv
// Shared encodings for the timer configuration sequencer: command ops,
// timer register offsets, CTRL bit layout, FSM states and the per-step transfer record.
package tim_cfg_pkg;

    typedef enum logic [1:0] {
        OP_START    = 2'b00,
        OP_STOP     = 2'b01,
        OP_READ_CUR = 2'b10,
        OP_CLR_INT  = 2'b11
    } op_e;

    localparam logic [7:0] OFF_LOAD   = 8'h00;
    localparam logic [7:0] OFF_CURVAL = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_EOI    = 8'h0C;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;
    localparam int CTRL_MASK_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [7:0]  addr;
        logic        write;
        logic [31:0] wdata;
    } xfer_t;

    function automatic logic [31:0] ctrl_word(input logic en, input logic mode, input logic mask);
        logic [31:0] w;
        w                = '0;
        w[CTRL_EN_BIT]   = en;
        w[CTRL_MODE_BIT] = mode;
        w[CTRL_MASK_BIT] = mask;
        return w;
    endfunction

endpackage

// File: rtl/tim_apb_mstr.sv
// Two-phase APB2 engine: a req cycle launches SETUP on the next cycle, then ACCESS.
// A req raised during ACCESS chains straight into the next SETUP, keeping psel high.
module tim_apb_mstr (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        req,
    input  logic [7:0]  addr,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [7:0]  m_paddr,
    output logic [31:0] m_pwdata,
    input  logic [31:0] m_prdata
);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
        end else if (req) begin
            m_psel    <= 1'b1;
            m_penable <= 1'b0;
            m_pwrite  <= write;
            m_paddr   <= addr;
            m_pwdata  <= wdata;
        end else if (m_psel && !m_penable) begin
            m_penable <= 1'b1;
        end else begin
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
        end
    end

    // No pready: every ACCESS cycle completes, read data is valid at its end.
    assign done  = m_psel & m_penable;
    assign rdata = m_prdata;

endmodule

// File: rtl/tim_cfg_seq.sv
// Command-driven APB master that starts, stops, reads or acknowledges a timer
// channel by issuing a short fixed sequence of register transfers.
module tim_cfg_seq
    import tim_cfg_pkg::*;
#(
    parameter int         NUM_CH    = 2,
    parameter int         CH_W      = 3,
    parameter logic [7:0] CH_STRIDE = 8'h14
) (
    input  logic            pclk,
    input  logic            presetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [CH_W-1:0] cmd_ch,
    input  logic [31:0]     cmd_load,
    input  logic            cmd_mode,
    input  logic            cmd_int_mask,
    output logic            rsp_valid,
    output logic            rsp_err,
    output logic [31:0]     rsp_data,
    output logic            busy,
    output logic            m_psel,
    output logic            m_penable,
    output logic            m_pwrite,
    output logic [7:0]      m_paddr,
    output logic [31:0]     m_pwdata,
    input  logic [31:0]     m_prdata
);

    state_e          state;
    logic [1:0]      step;
    op_e             op_q;
    logic [CH_W-1:0] ch_q;
    logic [31:0]     load_q;
    logic            mode_q;
    logic            mask_q;

    logic            accept;
    logic            legal;
    logic            cur_last;
    xfer_t           cur;
    xfer_t           nxt;
    xfer_t           rq;
    logic            req;
    logic            done;
    logic [31:0]     rdata;

    function automatic xfer_t xfer_at(input op_e op, input logic [CH_W-1:0] ch,
                                      input logic [31:0] load, input logic mode,
                                      input logic mask, input logic [1:0] stp);
        logic [7:0] base;
        xfer_t      x;
        base    = 8'(int'(ch) * int'(CH_STRIDE));
        x.addr  = base + OFF_CTRL;
        x.write = 1'b1;
        x.wdata = '0;
        case (op)
            OP_START: begin
                if (stp == 2'd1) begin
                    x.addr  = base + OFF_LOAD;
                    x.wdata = load;
                end else if (stp == 2'd2) begin
                    x.wdata = ctrl_word(1'b1, mode, mask);
                end
            end
            OP_READ_CUR: begin
                x.addr  = base + OFF_CURVAL;
                x.write = 1'b0;
            end
            OP_CLR_INT: begin
                x.addr  = base + OFF_EOI;
                x.write = 1'b0;
            end
            default: ;
        endcase
        return x;
    endfunction

    function automatic logic is_last(input op_e op, input logic [1:0] stp);
        return (op != OP_START) || (stp == 2'd2);
    endfunction

    assign accept   = cmd_valid & cmd_ready;
    assign legal    = int'(cmd_ch) < NUM_CH;
    assign cur      = xfer_at(op_q, ch_q, load_q, mode_q, mask_q, step);
    assign nxt      = xfer_at(op_q, ch_q, load_q, mode_q, mask_q, step + 2'd1);
    assign cur_last = is_last(op_q, step);

    // The first step is built from the live command so SETUP lands one cycle after accept.
    always_comb begin
        req = 1'b0;
        rq  = cur;
        if (state == ST_IDLE && accept && legal) begin
            req = 1'b1;
            rq  = xfer_at(op_e'(cmd_op), cmd_ch, cmd_load, cmd_mode, cmd_int_mask, 2'd0);
        end else if (state == ST_ACCESS && !cur_last) begin
            req = 1'b1;
            rq  = nxt;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= ST_IDLE;
            step      <= 2'd0;
            op_q      <= OP_START;
            ch_q      <= '0;
            load_q    <= '0;
            mode_q    <= 1'b0;
            mask_q    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= op_e'(cmd_op);
                        ch_q      <= cmd_ch;
                        load_q    <= cmd_load;
                        mode_q    <= cmd_mode;
                        mask_q    <= cmd_int_mask;
                        step      <= 2'd0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        rsp_data  <= '0;
                        if (legal) begin
                            state <= ST_SETUP;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done && !cur.write) begin
                        rsp_data <= rdata;
                    end
                    if (cur_last) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        step  <= step + 2'd1;
                        state <= ST_SETUP;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tim_apb_mstr u_apb (
        .pclk      (pclk),
        .presetn   (presetn),
        .req       (req),
        .addr      (rq.addr),
        .write     (rq.write),
        .wdata     (rq.wdata),
        .done      (done),
        .rdata     (rdata),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata)
    );

endmodule

// File: doc/tim_cfg_seq.md
Name: tim_cfg_seq

Overview:
- Hardware APB master that configures the dual-channel timers block (timers_top-style register map) from a simple command interface.
- Lets ETB or DMA logic start, stop, read or acknowledge a timer channel without CPU involvement.
- Sits beside tim6_tim_top. An external APB mux selects this master or the system APB. The mux is out of scope.
- Turns each command into a fixed sequence of 2-cycle APB2 transfers (no pready) and returns one response pulse.

Parameters:
- NUM_CH, 2, number of timer channels addressable; legal range 1..8.
- CH_W, 3, width of cmd_ch.
- CH_STRIDE, 8'h14, address stride between channel register banks.

Ports:
- pclk  in  1  clock; sole clock domain.
- presetn  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid&cmd_ready.
- cmd_op  in  2  00 START, 01 STOP, 10 READ_CUR, 11 CLR_INT.
- cmd_ch  in  CH_W  target channel.
- cmd_load  in  32  load count (START only).
- cmd_mode  in  1  1=user-defined (reload), 0=free-running (START only).
- cmd_int_mask  in  1  interrupt mask bit (START only).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  qualifies rsp_valid; set when cmd_ch>=NUM_CH.
- rsp_data  out  32  captured read data (READ_CUR/CLR_INT); 0 otherwise.
- busy  out  1  high from acceptance through the rsp_valid cycle.
- m_psel, m_penable, m_pwrite  out  1 each  APB master controls.
- m_paddr  out  8  APB address.
- m_pwdata  out  32  APB write data.
- m_prdata  in  32  APB read data.

Behaviour:
- Register map, per channel base = ch*CH_STRIDE:
  - LOAD +0x00
  - CURVAL +0x04
  - CTRL +0x08 (bit0 enable, bit1 mode, bit2 int_mask)
  - EOI +0x0C
- Command fields are latched at acceptance. Inputs are ignored while busy.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE→SETUP on accept with legal channel.
  - IDLE→RESP on accept with illegal channel (rsp_err=1, no APB activity).
  - SETUP→ACCESS always.
  - ACCESS→SETUP if further steps remain in the sequence, else ACCESS→RESP.
  - RESP→IDLE always.
- A 2-bit step counter indexes the sequence:
  - START: write CTRL=0; write LOAD=cmd_load; write CTRL={29'b0,int_mask,mode,1'b1}.
  - STOP: write CTRL=0.
  - READ_CUR: read CURVAL.
  - CLR_INT: read EOI (read clears the interrupt).
- APB signalling:
  - SETUP: m_psel=1, m_penable=0.
  - ACCESS: m_psel=1, m_penable=1.
  - m_paddr/m_pwrite/m_pwdata are stable across SETUP and ACCESS. m_psel stays asserted between back-to-back steps.
- Read data: m_prdata is sampled at the end of ACCESS. Data from the last read is held on rsp_data until the next acceptance.
- Latency, with the accept edge as cycle 0:
  - START: SETUP on cycles 1/3/5, ACCESS on 2/4/6, rsp_valid on cycle 7.
  - Single-access ops: rsp_valid on cycle 3.
  - Illegal channel: rsp_valid on cycle 1.
- cmd_ready=0 during the RESP cycle. Earliest next accept is the cycle after rsp_valid.
- Reset values: all outputs 0 except cmd_ready=1; FSM=IDLE; step=0.
- Reset mid-transfer: m_psel/m_penable drop asynchronously; the partial sequence is abandoned with no response. A timer may be left disabled; this is acceptable.
- A cmd_valid held high during busy is accepted once on return to IDLE (not queued).

Decomposition:
- Package tim_cfg_pkg holds:
  - op encodings
  - register offsets (LOAD/CURVAL/CTRL/EOI)
  - CTRL bit positions
  - FSM state typedef
- One natural sub-module: tim_apb_mstr. It is the 2-phase APB2 engine: given req/addr/write/wdata, it drives SETUP/ACCESS and returns done+rdata.
- tim_cfg_seq owns command latching, step sequencing and the response.

Test Plan:
- START ch1, load=0x0000_1000, mode=1, mask=0 → writes in order: 0x1C←0, 0x14←0x1000, 0x1C←0x3. rsp_valid at cycle 7, rsp_err=0, rsp_data=0.
- READ_CUR ch0, APB model returns 0x0000_0ABC → single read at paddr 0x04; rsp_valid cycle 3; rsp_data=0xABC.
- CLR_INT ch1 → read at 0x20; the timer model's interrupt clears; rsp_valid cycle 3.
- STOP with cmd_ch=5 (NUM_CH=2) → no m_psel activity; rsp_valid+rsp_err at cycle 1.
- cmd_valid held high across START → cmd_ready low cycles 1-7. Second command accepted cycle 8. m_psel continuous cycles 1-6 with penable toggling 0,1,0,1,0,1.
- presetn asserted during cycle 4 of START → m_psel=0 immediately. After release: cmd_ready=1, busy=0, no rsp_valid.
